// File: rtl/sr_latch_bank.sv
// Bank of N clocked set/reset channels with per-channel enable, MODE-selected s=r=1 resolution,
// sticky invalid flags and an optional saturating invalid counter (SR_LATCH_BANK_INV_CNT_EN).
module sr_latch_bank #(
  parameter int unsigned N            = 8,
  parameter int unsigned MODE         = 0,
  parameter logic [N-1:0] INIT        = '0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     en,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             clr_inv,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic [N-1:0]     changed,
  output logic [N-1:0]     inv_flag,
  output logic [CNT_W-1:0] inv_cnt
);

  logic [N-1:0] r_q;
  logic [N-1:0] r_changed;
  logic [N-1:0] r_flag;
  logic [N-1:0] w_q_next;
  logic [N-1:0] w_inv;
  logic [N-1:0] w_flag_next;

  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < int'(N); i++) begin
      if (en[i]) begin
        unique case ({s[i], r[i]})
          2'b10: w_q_next[i] = 1'b1;
          2'b01: w_q_next[i] = 1'b0;
          2'b11: begin
            case (MODE)
              0:       w_q_next[i] = 1'b1;
              1:       w_q_next[i] = 1'b0;
              2:       w_q_next[i] = ~r_q[i];
              default: w_q_next[i] = r_q[i];
            endcase
          end
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  // Toggle mode treats s=r=1 as a legal command, so it never counts as invalid.
  always_comb begin
    w_inv = '0;
    if (MODE != 2) begin
      w_inv = en & s & r;
    end
    // A new invalid event in the clearing cycle survives the clear.
    w_flag_next = (clr_inv ? '0 : r_flag) | w_inv;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= INIT;
      r_changed <= '0;
      r_flag    <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
      r_flag    <= w_flag_next;
    end
  end

`ifdef SR_LATCH_BANK_INV_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_base = clr_inv ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if ((|w_inv) && (w_cnt_base != {CNT_W{1'b1}})) begin
      w_cnt_next = w_cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign inv_cnt = r_cnt;
`else
  assign inv_cnt = '0;
`endif

  assign q        = r_q;
  assign qbar     = ~r_q;
  assign changed  = r_changed;
  assign inv_flag = r_flag;

endmodule
